controle_reservatorio: RTL and testbench
========================================

// Module: controle_reservatorio
// PURPOSE
//  Upstream fill controller for maquina_maluca: drives the water valve on request,
//  counts flow-meter pulses to a target volume, emits the one-cycle agua_enchida
//  pulse that maquina_maluca consumes. Detects stalled flow (timeout) and aborts
//  safely when the request is withdrawn.
// PARAMETERS
//  ALVO     8   flow pulses that make a full tank (1..2**CNT_W-1)
//  TIMEOUT  64  max cycles in ENCHENDO without a flow pulse before FALHA (>=2)
//  CNT_W    8   width of nivel and of the timeout counter
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  reset         in   1      synchronous, active-high
//  encher_req    in   1      level request to fill; held high by requester
//  fluxo_pulso   in   1      one-cycle pulse per unit of water from flow meter
//  valvula       out  1      valve open
//  agua_enchida  out  1      one-cycle pulse: target volume reached
//  erro          out  1      flow stalled (timeout); high while in FALHA
//  nivel         out  CNT_W  pulses counted in the current fill
//  estado        out  3      FSM state code for debug/monitor
// BEHAVIOUR
//  All outputs registered. Reset: state OCIOSO, valvula=0, agua_enchida=0, erro=0,
//  nivel=0, timeout counter=0; reset wins over every other event.
//  States (estado code): OCIOSO=0, ENCHENDO=1, CHEIO=2, AGUARDA=3, FALHA=4.
//  OCIOSO: valvula=0. encher_req=1 sampled -> ENCHENDO next edge; same edge
//   clears nivel and timeout counter; valvula=1 from that cycle (1-cycle latency).
//  ENCHENDO: valvula=1. Checked in priority order each edge:
//   1) encher_req=0 -> OCIOSO (abort); valvula=0; nivel held; no pulse, no erro.
//   2) fluxo_pulso=1: nivel+1, timeout counter cleared; if nivel+1==ALVO -> CHEIO.
//   3) no pulse: timeout counter+1; reaching TIMEOUT -> FALHA.
//   Pulse on the same cycle the counter would expire: pulse wins (no FALHA).
//  CHEIO: exactly one cycle; agua_enchida=1, valvula=0 -> AGUARDA unconditionally.
//  AGUARDA: valvula=0; wait encher_req=0 -> OCIOSO. Holding request never refills.
//  FALHA: valvula=0, erro=1; encher_req=0 -> OCIOSO, erro cleared same edge.
//  fluxo_pulso ignored in every state except ENCHENDO; nivel never exceeds ALVO,
//  never wraps. agua_enchida is never asserted outside CHEIO (exactly 1 cycle/fill).
//  Timeout counter saturates; width CNT_W must hold TIMEOUT.
//  Reset asserted mid-fill: valve closes on that edge, no agua_enchida.
//  Integration: agua_enchida drives maquina_maluca.agua_enchida directly;
//  encher_req comes from its fill-state decode.
// TESTING (bench uses ALVO=4, TIMEOUT=10, 10 ns clock)
//  1 Reset 2 cycles -> valvula=0, agua_enchida=0, erro=0, nivel=0, estado=0.
//  2 req=1, 4 pulses every 3 cycles -> valvula=1 1 cycle after req; nivel 1..4;
//    agua_enchida high exactly 1 cycle after 4th pulse; estado 2 then 3; valve 0.
//  3 Keep req=1 after fill, send 3 more pulses -> stays AGUARDA, nivel=4, no pulse;
//    drop req -> estado=0 next edge.
//  4 req=1, no pulses -> erro=1, estado=4 after 10 cycles in ENCHENDO, valvula=0;
//    pulse at cycle 10 exactly instead -> no FALHA, nivel=1.
//  5 req=1, 2 pulses, req=0 -> estado=0, valvula=0, nivel=2 held, no agua_enchida;
//    new req -> nivel cleared to 0.
//  6 reset=1 during ENCHENDO with pulse same cycle -> all outputs reset values.

Source files
------------

// File: rtl/controle_reservatorio.sv
// controle_reservatorio
//   Upstream fill controller for maquina_maluca. It opens the water valve while
//   a fill is requested and counts flow-meter pulses up to ALVO. When the target
//   volume is reached, it emits a one-cycle agua_enchida pulse. If no flow pulse
//   arrives for TIMEOUT cycles, it flags a fault. If the request is withdrawn
//   mid-fill, the fill is aborted.
//
// Ports
//   clk          in   rising-edge system clock
//   reset        in   synchronous, active-high
//   encher_req   in   level fill request from the requester
//   fluxo_pulso  in   one-cycle pulse per unit of water delivered
//   valvula      out  valve open (registered)
//   agua_enchida out  one-cycle pulse when the target volume is reached
//   erro         out  high while in the stalled-flow fault state
//   nivel        out  flow pulses counted in the current fill
//   estado       out  FSM state code (0 idle .. 4 fault) for monitoring
module controle_reservatorio #(
    parameter int unsigned ALVO    = 8,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             encher_req,
    input  logic             fluxo_pulso,
    output logic             valvula,
    output logic             agua_enchida,
    output logic             erro,
    output logic [CNT_W-1:0] nivel,
    output logic [2:0]       estado
);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ENCHENDO = 3'd1,
        CHEIO    = 3'd2,
        AGUARDA  = 3'd3,
        FALHA    = 3'd4
    } estado_t;

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] nivel_q, nivel_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             valvula_q, valvula_d;
    logic             agua_q, agua_d;
    logic             erro_q, erro_d;

    logic [CNT_W-1:0] nivel_inc;
    logic             tmo_hit;

    assign nivel_inc = nivel_q + 1'b1;
    // The counter reaches TIMEOUT on this edge.
    // ">=" keeps a saturated counter in the fault path.
    assign tmo_hit   = (tmo_q >= CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        nivel_d = nivel_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            OCIOSO: begin
                if (encher_req) begin
                    state_d = ENCHENDO;
                    nivel_d = '0;
                    tmo_d   = '0;
                end
            end
            ENCHENDO: begin
                // Priority: abort, then flow pulse, then timeout.
                // A pulse on the expiring cycle therefore wins.
                if (!encher_req) begin
                    state_d = OCIOSO;
                end else if (fluxo_pulso) begin
                    nivel_d = nivel_inc;
                    tmo_d   = '0;
                    if (nivel_inc == CNT_W'(ALVO)) begin
                        state_d = CHEIO;
                    end
                end else begin
                    if (tmo_q != '1) begin
                        tmo_d = tmo_q + 1'b1;
                    end
                    if (tmo_hit) begin
                        state_d = FALHA;
                    end
                end
            end
            CHEIO:   state_d = AGUARDA;
            AGUARDA: if (!encher_req) state_d = OCIOSO;
            FALHA:   if (!encher_req) state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase

        // Outputs are registered from the next state.
        // They therefore line up with the state register.
        valvula_d = (state_d == ENCHENDO);
        agua_d    = (state_d == CHEIO);
        erro_d    = (state_d == FALHA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= OCIOSO;
            nivel_q   <= '0;
            tmo_q     <= '0;
            valvula_q <= 1'b0;
            agua_q    <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            nivel_q   <= nivel_d;
            tmo_q     <= tmo_d;
            valvula_q <= valvula_d;
            agua_q    <= agua_d;
            erro_q    <= erro_d;
        end
    end

    assign valvula      = valvula_q;
    assign agua_enchida = agua_q;
    assign erro         = erro_q;
    assign nivel        = nivel_q;
    assign estado       = state_q;

endmodule

// File: tb/tb_controle_reservatorio.sv
module tb_controle_reservatorio;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       encher_req = 1'b0;
    logic       fluxo_pulso = 1'b0;
    logic       valvula, agua_enchida, erro;
    logic [7:0] nivel;
    logic [2:0] estado;

    always #5 clk = ~clk;

    controle_reservatorio #(.ALVO(4), .TIMEOUT(10), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .encher_req   (encher_req),
        .fluxo_pulso  (fluxo_pulso),
        .valvula      (valvula),
        .agua_enchida (agua_enchida),
        .erro         (erro),
        .nivel        (nivel),
        .estado       (estado)
    );

    typedef struct {
        logic       rst, req, pul;
        logic       v, a, e;
        logic [7:0] n;
        logic [2:0] s;
    } vec_t;

    vec_t        tab[$];
    logic [13:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function void add(input logic rst, input logic req, input logic pul,
                      input logic v, input logic a, input logic e,
                      input logic [7:0] n, input logic [2:0] s);
        vec_t t;
        t.rst = rst; t.req = req; t.pul = pul;
        t.v = v; t.a = a; t.e = e; t.n = n; t.s = s;
        tab.push_back(t);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [13:0] got, input logic [13:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s[%0d]: got v=%b a=%b e=%b n=%0d s=%0d, expected v=%b a=%b e=%b n=%0d s=%0d",
                     name, idx, got[13], got[12], got[11], got[10:3], got[2:0],
                     expv[13], expv[12], expv[11], expv[10:3], expv[2:0]);
        end
    endtask

    function automatic logic [13:0] outs();
        return {valvula, agua_enchida, erro, nivel, estado};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int agua_cnt;
        bit reached;
        int gap;

        // ---- vector table: inputs before an edge, outputs after it ----
        // reset
        add(1,0,0, 0,0,0, 0,0);
        add(1,0,0, 0,0,0, 0,0);
        // full fill, a pulse every 3 cycles
        add(0,1,0, 1,0,0, 0,1);
        for (int p = 1; p <= 3; p++) begin
            add(0,1,0, 1,0,0, 8'(p-1),1);
            add(0,1,0, 1,0,0, 8'(p-1),1);
            add(0,1,1, 1,0,0, 8'(p),1);
        end
        add(0,1,0, 1,0,0, 3,1);
        add(0,1,0, 1,0,0, 3,1);
        add(0,1,1, 0,1,0, 4,2);          // 4th pulse -> CHEIO, one agua cycle
        add(0,1,0, 0,0,0, 4,3);          // AGUARDA
        // extra pulses while held in AGUARDA are ignored
        for (int i = 0; i < 3; i++) add(0,1,1, 0,0,0, 4,3);
        add(0,0,0, 0,0,0, 4,0);
        // timeout: 10 edges in ENCHENDO without a pulse
        add(0,1,0, 1,0,0, 0,1);
        for (int i = 0; i < 9; i++) add(0,1,0, 1,0,0, 0,1);
        add(0,1,0, 0,0,1, 0,4);
        add(0,1,0, 0,0,1, 0,4);
        add(0,0,0, 0,0,0, 0,0);          // erro clears on the same edge
        // pulse on the 10th cycle instead -> no fault
        add(0,1,0, 1,0,0, 0,1);
        for (int i = 0; i < 9; i++) add(0,1,0, 1,0,0, 0,1);
        add(0,1,1, 1,0,0, 1,1);
        add(0,1,0, 1,0,0, 1,1);
        add(0,0,0, 0,0,0, 1,0);
        // abort mid-fill holds nivel; a new request clears it
        add(0,1,0, 1,0,0, 0,1);
        add(0,1,1, 1,0,0, 1,1);
        add(0,1,1, 1,0,0, 2,1);
        add(0,0,0, 0,0,0, 2,0);
        add(0,0,1, 0,0,0, 2,0);
        add(0,1,0, 1,0,0, 0,1);
        // reset mid-fill with a pulse on the same cycle
        add(0,1,1, 1,0,0, 1,1);
        add(1,1,1, 0,0,0, 0,0);
        add(0,0,0, 0,0,0, 0,0);

        foreach (tab[k]) begin
            reset       = tab[k].rst;
            encher_req  = tab[k].req;
            fluxo_pulso = tab[k].pul;
            exp_q.push_back({tab[k].v, tab[k].a, tab[k].e, tab[k].n, tab[k].s});
            tick();
            check("vec", k, outs(), exp_q.pop_front());
        end

        // ---- hand sequence: fill with random spacing, agua exactly once ----
        encher_req = 1'b1; fluxo_pulso = 1'b0; reset = 1'b0;
        agua_cnt = 0; reached = 0; gap = 0;
        for (int c = 0; c < 100 && !reached; c++) begin
            if (gap == 0) begin
                fluxo_pulso = 1'b1;
                gap = $urandom_range(1, 3);
            end else begin
                fluxo_pulso = 1'b0;
                gap--;
            end
            tick();
            if (agua_enchida) agua_cnt++;
            if (estado == 3'd3) reached = 1;
        end
        fluxo_pulso = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (agua_enchida) agua_cnt++;
        end
        n_tests++;
        if (!reached) begin
            n_fail++;
            $display("FAIL rand_fill_reach: got estado=%0d, expected 3 within 100 cycles", estado);
        end
        check("rand_fill_level", 0, {7'd0, nivel}, 14'd4);
        check("rand_fill_agua", 0, 14'(agua_cnt), 14'd1);
        encher_req = 1'b0;
        tick();
        check("rand_fill_drop", 0, outs(), {1'b0, 1'b0, 1'b0, 8'd4, 3'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
